// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA raster timing controller.
//   - phase_e        : position of an axis counter inside its line/frame
//                      (active, front porch, sync, back porch).
//   - DEF_*          : 640x480@60 Hz timing (25.175 MHz pixel clock).
//   - axis_total()   : length of one axis period from its four segments.
//   - h_total()/v_total() : named wrappers used where intent matters.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

    // Horizontal timing, in pixel clocks.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Sync pulses are active-low for the 640x480 standard mode.
    localparam logic DEF_SYNC_POL = 1'b0;

    // Coordinate width; both totals must fit in 2**DEF_CNT_W.
    localparam int DEF_CNT_W = 10;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis: a wrapping counter 0..TOTAL-1 plus a phase register
//   that tracks which segment (active, front porch, sync, back porch) the
//   current count sits in. Used once for pixels within a line and once for
//   lines within a frame.
//   Every segment length must be at least 1 and TOTAL must be <= 2**CNT_W.
//
// Ports
//   i_clk      in   1      pixel clock
//   i_rst_n    in   1      asynchronous reset, active low
//   i_clr      in   1      synchronous restart to count 0 / PH_ACT (wins over i_inc)
//   i_inc      in   1      advance the count by one on this edge
//   o_count    out  CNT_W  current count
//   o_phase    out  2      current phase (phase_e encoding)
//   o_wrap     out  1      i_inc && count == TOTAL-1 (combinational)
//   o_in_sync  out  1      current count lies in the sync segment
// ----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic [1:0]       o_phase,
    output logic             o_wrap,
    output logic             o_in_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    // Last count of each segment; the phase moves on as the count leaves it.
    localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYN = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q;
    phase_e           phase_q;
    logic             at_last;

    assign at_last = (count_q == LAST_CNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments so count and phase both see the
        // pre-edge count; blocking here would make the phase decode race it.
        if (!i_rst_n) begin
            count_q <= '0;
            phase_q <= PH_ACT;
        end else if (i_clr) begin
            count_q <= '0;
            phase_q <= PH_ACT;
        end else if (i_inc) begin
            count_q <= at_last ? '0 : count_q + CNT_W'(1);
            case (phase_q)
                PH_ACT:  if (count_q == LAST_ACT) phase_q <= PH_FP;
                PH_FP:   if (count_q == LAST_FP)  phase_q <= PH_SYN;
                PH_SYN:  if (count_q == LAST_SYN) phase_q <= PH_BP;
                PH_BP:   if (at_last)             phase_q <= PH_ACT;
                default: phase_q <= PH_ACT;
            endcase
        end
    end

    assign o_count   = count_q;
    assign o_phase   = phase_q;
    assign o_wrap    = i_inc && at_last;
    assign o_in_sync = (phase_q == PH_SYN);

endmodule

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl
//   Raster timing controller for the VGA output path. A horizontal axis
//   counter steps every pixel clock; a vertical axis counter steps on each
//   horizontal wrap. All outputs are registered and decoded from the counter
//   values held before the edge, so they trail the counters by one cycle.
//   o_video_on is the select of the downstream 24-bit RGB blanking mux:
//   pixel data passes only while it is 1, black otherwise.
//   i_enable=0 parks the raster at (0,0) with idle outputs; the first enabled
//   edge afterwards emits the frame origin with both start pulses.
//
// Ports
//   i_clk          in   1      pixel clock
//   i_rst_n        in   1      asynchronous reset, active low
//   i_enable       in   1      run raster; 0 = idle and restart
//   o_hsync        out  1      horizontal sync, asserted level = SYNC_POL
//   o_vsync        out  1      vertical sync, asserted level = SYNC_POL
//   o_video_on     out  1      inside the visible area
//   o_x            out  CNT_W  horizontal count 0..H_TOTAL-1 (blanking included)
//   o_y            out  CNT_W  vertical count 0..V_TOTAL-1 (blanking included)
//   o_line_start   out  1      one-cycle pulse with o_x==0
//   o_frame_start  out  1      one-cycle pulse with o_x==0 && o_y==0
// ----------------------------------------------------------------------------
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL,
    parameter int   CNT_W    = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_video_on,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_line_start,
    output logic             o_frame_start
);

    logic             clr;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic [1:0]       h_phase;
    logic [1:0]       v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync;
    logic             v_sync;
    logic             origin_q;

    assign clr = ~i_enable;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (clr),
        .i_inc     (1'b1),
        .o_count   (h_count),
        .o_phase   (h_phase),
        .o_wrap    (h_wrap),
        .o_in_sync (h_sync)
    );

    // Lines advance only when the pixel counter wraps, so vsync edges always
    // coincide with h==0 and the whole line is covered.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (clr),
        .i_inc     (h_wrap),
        .o_count   (v_count),
        .o_phase   (v_phase),
        .o_wrap    (v_wrap),
        .o_in_sync (v_sync)
    );

    // origin_q is 1 exactly while the counters hold (0,0): after reset, after
    // an idle edge, or on the edge following the end-of-frame wrap. The
    // horizontal counter steps every enabled cycle, so it clears one cycle
    // later. This avoids a second wide compare for the frame pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            origin_q <= 1'b1;
        end else if (clr) begin
            origin_q <= 1'b1;
        end else begin
            origin_q <= v_wrap;
        end
    end

    // Output registers: idle levels while reset or disabled, otherwise a
    // one-cycle-delayed decode of the pre-edge counter state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_video_on    <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (!i_enable) begin
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_video_on    <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
            o_video_on    <= (h_phase == PH_ACT) && (v_phase == PH_ACT);
            o_x           <= h_count;
            o_y           <= v_count;
            o_line_start  <= (h_count == '0);
            o_frame_start <= origin_q;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Two controllers share clock, reset and enable: one with 640x480 timing
//   and one with a tiny raster (H 4/1/2/1, V 3/1/1/1) so whole frames are
//   short. A reference model derives every output from the number of enabled
//   edges since the last restart; a vector table and hand-written sequences
//   cover start-up, porches, enable drop and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        logic en;
        out_t exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    // Default-timing instance.
    logic       d_hs, d_vs, d_von, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    out_t       d_out;

    // Small-timing instance.
    logic       s_hs, s_vs, s_von, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    out_t       s_out;

    assign d_out = {d_hs, d_vs, d_von, d_x, d_y, d_ls, d_fs};
    assign s_out = {s_hs, s_vs, s_von, s_x, s_y, s_ls, s_fs};

    vga_timing_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .o_hsync       (d_hs),
        .o_vsync       (d_vs),
        .o_video_on    (d_von),
        .o_x           (d_x),
        .o_y           (d_y),
        .o_line_start  (d_ls),
        .o_frame_start (d_fs)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b0), .CNT_W (10)
    ) dut_s (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .o_hsync       (s_hs),
        .o_vsync       (s_vs),
        .o_video_on    (s_von),
        .o_x           (s_x),
        .o_y           (s_y),
        .o_line_start  (s_ls),
        .o_frame_start (s_fs)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                     name, act.x, act.y, act.hs, act.vs, act.von, act.ls, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.ls, exp.fs);
        end
    endtask

    function automatic out_t mk(input bit hs, input bit vs, input bit von,
                                input int x, input int y, input bit ls, input bit fs);
        out_t o;
        o.hs  = hs;
        o.vs  = vs;
        o.von = von;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.ls  = ls;
        o.fs  = fs;
        return o;
    endfunction

    // Expected outputs for the k-th enabled edge of a raster (sync active-low).
    function automatic out_t model(input int k, input bit act,
                                   input int ha, input int hf, input int hsn, input int hb,
                                   input int va, input int vf, input int vsn, input int vb);
        int ht = ha + hf + hsn + hb;
        int vt = va + vf + vsn + vb;
        int x  = k % ht;
        int y  = (k / ht) % vt;
        if (!act) return mk(1, 1, 0, 0, 0, 0, 0);
        return mk(!(x >= ha + hf && x < ha + hf + hsn),
                  !(y >= va + vf && y < va + vf + vsn),
                  (x < ha) && (y < va), x, y, x == 0, (x == 0) && (y == 0));
    endfunction

    // Model state: k counts enabled edges since the last restart; mk/mact are
    // the index and activity of the outputs currently expected.
    int k_next = 0;
    int mk_cur = 0;
    bit mact   = 1'b0;
    bit sb_on  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_next <= 0;
            mk_cur <= 0;
            mact   <= 1'b0;
        end else if (en) begin
            mk_cur <= k_next;
            k_next <= k_next + 1;
            mact   <= 1'b1;
        end else begin
            k_next <= 0;
            mact   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (sb_on) begin
            check_out("sb_default", d_out, model(mk_cur, mact, 640, 16, 96, 48, 480, 10, 2, 33));
            check_out("sb_small", s_out, model(mk_cur, mact, 4, 1, 2, 1, 3, 1, 1, 1));
        end
    end

    localparam out_t IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0, x: 10'd0, y: 10'd0, ls: 1'b0, fs: 1'b0};

    vec_t vecs[13];

    initial begin
        int   hs_low, hs_min, hs_max, ls_cnt, ls_prev, von_falls, vs_low, y_min, y_max;
        int   fs_cnt, fs_prev, von_cnt, wraps;
        logic prev_von;
        int   prev_x, prev_y;
        bit   found;

        // Hand-derived small-raster vectors (H 4/1/2/1 -> 8 px, V 3/1/1/1 -> 6 lines).
        vecs[0]  = '{1'b0, IDLE};
        vecs[1]  = '{1'b1, mk(1, 1, 1, 0, 0, 1, 1)};
        vecs[2]  = '{1'b1, mk(1, 1, 1, 1, 0, 0, 0)};
        vecs[3]  = '{1'b1, mk(1, 1, 1, 2, 0, 0, 0)};
        vecs[4]  = '{1'b1, mk(1, 1, 1, 3, 0, 0, 0)};
        vecs[5]  = '{1'b1, mk(1, 1, 0, 4, 0, 0, 0)};
        vecs[6]  = '{1'b1, mk(0, 1, 0, 5, 0, 0, 0)};
        vecs[7]  = '{1'b1, mk(0, 1, 0, 6, 0, 0, 0)};
        vecs[8]  = '{1'b1, mk(1, 1, 0, 7, 0, 0, 0)};
        vecs[9]  = '{1'b1, mk(1, 1, 1, 0, 1, 1, 0)};
        vecs[10] = '{1'b0, IDLE};
        vecs[11] = '{1'b1, mk(1, 1, 1, 0, 0, 1, 1)};
        vecs[12] = '{1'b1, mk(1, 1, 1, 1, 0, 0, 0)};

        // Reset state, held through clock edges with enable high.
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_default", d_out, IDLE);
        check_out("reset_small", s_out, IDLE);

        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        sb_on = 1'b1;

        // Vector table on the small raster.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            en = vecs[i].en;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), s_out, vecs[i].exp);
        end

        // First enabled edge after idle on the 640x480 raster.
        @(negedge clk) en = 1'b0;
        @(posedge clk) #1 check_out("t1_idle", d_out, IDLE);
        @(negedge clk) en = 1'b1;
        @(posedge clk) #1 check_out("t1_first", d_out, mk(1, 1, 1, 0, 0, 1, 1));
        @(posedge clk) #1;
        check("t1_second_x", int'(d_x), 1);
        check("t1_second_ls", int'(d_ls), 0);
        check("t1_second_fs", int'(d_fs), 0);

        // Two full lines starting from o_x==1.
        hs_low = 0; hs_min = 9999; hs_max = -1; ls_cnt = 0; ls_prev = -1; von_falls = 0;
        prev_von = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (!d_hs) begin
                hs_low++;
                if (int'(d_x) < hs_min) hs_min = int'(d_x);
                if (int'(d_x) > hs_max) hs_max = int'(d_x);
            end
            if (d_ls) begin
                if (ls_prev >= 0) check("t2_line_period", i - ls_prev, 800);
                ls_prev = i;
                ls_cnt++;
            end
            if (prev_von && !d_von) begin
                von_falls++;
                check("t2_von_fall_x", int'(d_x), 640);
            end
            prev_von = d_von;
        end
        check("t2_hsync_low_cycles", hs_low, 192);
        check("t2_hsync_first_x", hs_min, 656);
        check("t2_hsync_last_x", hs_max, 751);
        check("t2_line_starts", ls_cnt, 2);
        check("t2_von_falls", von_falls, 2);

        // Two full frames on the small raster, from a fresh start.
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
        vs_low = 0; y_min = 9999; y_max = -1; fs_cnt = 0; fs_prev = -1; von_cnt = 0; wraps = 0;
        prev_x = 0; prev_y = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (!s_vs) begin
                vs_low++;
                if (int'(s_y) < y_min) y_min = int'(s_y);
                if (int'(s_y) > y_max) y_max = int'(s_y);
            end
            if (s_fs) begin
                if (fs_prev >= 0) check("t3_frame_period", i - fs_prev, 48);
                fs_prev = i;
                fs_cnt++;
            end
            if (s_von) von_cnt++;
            if (i > 0 && prev_y == 5 && int'(s_y) == 0) begin
                wraps++;
                check("t3_wrap_prev_x", prev_x, 7);
                check("t3_wrap_x", int'(s_x), 0);
            end
            prev_x = int'(s_x);
            prev_y = int'(s_y);
        end
        check("t3_vsync_low_cycles", vs_low, 16);
        check("t3_vsync_first_y", y_min, 4);
        check("t3_vsync_last_y", y_max, 4);
        check("t3_frame_starts", fs_cnt, 2);
        check("t3_y_wraps", wraps, 1);
        check("t4_video_on_cycles", von_cnt, 24);

        // Enable drop mid-frame at (2,1) for five cycles, then restart.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_x == 10'd2 && s_y == 10'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reach_point", int'(found), 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #1 check_out("t5_idle", s_out, IDLE);
        end
        @(negedge clk) en = 1'b1;
        @(posedge clk) #1 check_out("t5_restart", s_out, mk(1, 1, 1, 0, 0, 1, 1));

        // Random enable drops and occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                check_out("rand_async_default", d_out, IDLE);
                check_out("rand_async_small", s_out, IDLE);
                #1 rst_n = 1'b1;
            end
        end

        // Asynchronous reset in the middle of hsync, between clock edges.
        @(negedge clk) en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (d_x == 10'd700) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reach_x700", int'(found), 1);
        check("t6_hsync_in_sync", int'(d_hs), 0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_hsync", int'(d_hs), 1);
        check("t6_video_on", int'(d_von), 0);
        check("t6_x", int'(d_x), 0);
        check_out("t6_all", d_out, IDLE);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);

        sb_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
